// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of an asynchronous input in tick units.
// Optional glitch filter enabled by defining PWM_CAPTURE_FILTER_EN.
module pwm_capture #(
    parameter int unsigned CNT_W       = 10,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 1000,
    parameter int unsigned FILTER_LEN  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             stuck,
    output logic             stuck_level
);

    if (SYNC_STAGES < 2 || TIMEOUT >= (64'd1 << CNT_W) || FILTER_LEN < 1) begin : g_bad_params
        $error("pwm_capture: invalid parameter combination");
    end

    typedef enum logic [1:0] {IDLE, MEAS_HIGH, MEAS_LOW} state_t;

    localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lvl_src;
    logic                   lvl_q;
    logic                   rise_q, fall_q;
    logic [CNT_W-1:0]       pcnt_q, pcnt_d;
    logic [CNT_W-1:0]       hcnt_q, hcnt_d;
    logic [CNT_W-1:0]       shadow_q, shadow_d;
    logic [CNT_W-1:0]       idle_q, idle_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic [CNT_W-1:0]       high_q, high_d;
    logic                   valid_q, valid_d;
    logic                   stuck_q, stuck_d;
    logic                   slev_q, slev_d;
    logic [CNT_W-1:0]       start_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    logic          filt_q;
    logic [FW-1:0] fcnt_q;

    // Level flips only after FILTER_LEN consecutive cycles of disagreement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= 1'b0;
            fcnt_q <= '0;
        end else if (sync_q[SYNC_STAGES-1] != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                filt_q <= sync_q[SYNC_STAGES-1];
                fcnt_q <= '0;
            end else begin
                fcnt_q <= fcnt_q + FW'(1);
            end
        end else begin
            fcnt_q <= '0;
        end
    end
    assign lvl_src = filt_q;
`else
    assign lvl_src = sync_q[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            lvl_q  <= lvl_src;
            rise_q <= lvl_src & ~lvl_q;
            fall_q <= ~lvl_src & lvl_q;
        end
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && v != '1) ? v + CNT_W'(1) : v;
    endfunction

    assign start_val = CNT_W'(tick);

    always_comb begin
        state_d  = state_q;
        pcnt_d   = pcnt_q;
        hcnt_d   = hcnt_q;
        shadow_d = shadow_q;
        idle_d   = idle_q;
        period_d = period_q;
        high_d   = high_q;
        valid_d  = 1'b0;
        stuck_d  = stuck_q;
        slev_d   = slev_q;
        case (state_q)
            IDLE: begin
                pcnt_d = '0;
                hcnt_d = '0;
                if (rise_q) begin
                    state_d = MEAS_HIGH;
                    pcnt_d  = start_val;
                    hcnt_d  = start_val;
                    idle_d  = '0;
                end else begin
                    idle_d = sat_inc(idle_q, tick);
                    if (idle_q >= TO && !stuck_q) begin
                        stuck_d = 1'b1;
                        slev_d  = lvl_q;
                    end
                end
            end
            MEAS_HIGH: begin
                if (pcnt_q >= TO) begin
                    stuck_d = 1'b1;
                    slev_d  = lvl_q;
                    state_d = IDLE;
                    pcnt_d  = '0;
                    hcnt_d  = '0;
                    idle_d  = '0;
                end else if (fall_q) begin
                    shadow_d = hcnt_q;
                    pcnt_d   = sat_inc(pcnt_q, tick);
                    state_d  = MEAS_LOW;
                end else begin
                    pcnt_d = sat_inc(pcnt_q, tick);
                    hcnt_d = sat_inc(hcnt_q, tick);
                end
            end
            MEAS_LOW: begin
                if (rise_q) begin
                    period_d = pcnt_q;
                    high_d   = shadow_q;
                    valid_d  = 1'b1;
                    stuck_d  = 1'b0;
                    pcnt_d   = start_val;
                    hcnt_d   = start_val;
                    state_d  = MEAS_HIGH;
                end else if (pcnt_q >= TO) begin
                    stuck_d = 1'b1;
                    slev_d  = lvl_q;
                    state_d = IDLE;
                    pcnt_d  = '0;
                    hcnt_d  = '0;
                    idle_d  = '0;
                end else begin
                    pcnt_d = sat_inc(pcnt_q, tick);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pcnt_q   <= '0;
            hcnt_q   <= '0;
            shadow_q <= '0;
            idle_q   <= '0;
            period_q <= '0;
            high_q   <= '0;
            valid_q  <= 1'b0;
            stuck_q  <= 1'b0;
            slev_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pcnt_q   <= pcnt_d;
            hcnt_q   <= hcnt_d;
            shadow_q <= shadow_d;
            idle_q   <= idle_d;
            period_q <= period_d;
            high_q   <= high_d;
            valid_q  <= valid_d;
            stuck_q  <= stuck_d;
            slev_q   <= slev_d;
        end
    end

    assign period      = period_q;
    assign high_time   = high_q;
    assign valid       = valid_q;
    assign stuck       = stuck_q;
    assign stuck_level = slev_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed self-checking bench for pwm_capture (default parameters).
module tb_pwm_capture;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic       sig_in;
    logic [9:0] period;
    logic [9:0] high_time;
    logic       valid;
    logic       stuck;
    logic       stuck_level;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int vcnt = 0, vper = 0, vht = 0, vcyc = 0, vprev = 0, vfirst = 0;
    int stuck_cyc = -1;
    logic stuck_prev = 1'b0;
    int tick_div = 1;
    int tphase = 0;

`ifdef PWM_CAPTURE_FILTER_EN
    localparam int FLAT = 4;
    localparam int MINP = 5;
`else
    localparam int FLAT = 0;
    localparam int MINP = 3;
`endif

    pwm_capture #(
        .CNT_W(10),
        .SYNC_STAGES(2),
        .TIMEOUT(1000),
        .FILTER_LEN(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .tick(tick),
        .sig_in(sig_in),
        .period(period),
        .high_time(high_time),
        .valid(valid),
        .stuck(stuck),
        .stuck_level(stuck_level)
    );

    always #5 clk = ~clk;

    // Records valid pulses and the stuck rising edge, sampled 2 units after posedge.
    always @(posedge clk) begin
        cyc++;
        #2;
        if (valid) begin
            vprev = vcyc;
            vcyc  = cyc;
            if (vcnt == 0) vfirst = cyc;
            vcnt++;
            vper = period;
            vht  = high_time;
        end
        if (stuck && !stuck_prev) stuck_cyc = cyc;
        stuck_prev = stuck;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got time limit expired, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic drive_cycle(input logic s);
        sig_in = s;
        tick   = (tphase == 0);
        tphase = (tphase + 1) % tick_div;
        @(negedge clk);
    endtask

    task automatic pulse(input int hi, input int lo, input int n);
        repeat (n) begin
            repeat (hi) drive_cycle(1'b1);
            repeat (lo) drive_cycle(1'b0);
        end
    endtask

    task automatic test_reset;
        rst_n  = 1'b0;
        sig_in = 1'b0;
        tick   = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (period !== 10'd0) begin errors++; $display("FAIL rst_period: got %0d expected 0", period); end
        checks++; if (high_time !== 10'd0) begin errors++; $display("FAIL rst_high: got %0d expected 0", high_time); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", valid); end
        checks++; if (stuck !== 1'b0) begin errors++; $display("FAIL rst_stuck: got %b expected 0", stuck); end
        checks++; if (stuck_level !== 1'b0) begin errors++; $display("FAIL rst_slev: got %b expected 0", stuck_level); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_square;
        int c0;
        vcnt = 0;
        repeat (5) drive_cycle(1'b0);
        pulse(10, 10, 1);
        checks++; if (vcnt !== 0) begin errors++; $display("FAIL sq_first_rise: got %0d valids expected 0", vcnt); end
        c0 = cyc;
        pulse(10, 10, 4);
        checks++; if (vcnt !== 4) begin errors++; $display("FAIL sq_count: got %0d expected 4", vcnt); end
        checks++; if (vper !== 20) begin errors++; $display("FAIL sq_period: got %0d expected 20", vper); end
        checks++; if (vht !== 10) begin errors++; $display("FAIL sq_high: got %0d expected 10", vht); end
        checks++; if (vcyc - vprev !== 20) begin errors++; $display("FAIL sq_spacing: got %0d expected 20", vcyc - vprev); end
        checks++; if (vfirst - c0 !== 4 + FLAT) begin errors++; $display("FAIL sq_latency: got %0d expected %0d", vfirst - c0, 4 + FLAT); end
        checks++; if (stuck !== 1'b0) begin errors++; $display("FAIL sq_stuck: got %b expected 0", stuck); end
    endtask

    task automatic test_duty;
        pulse(MINP, 20 - MINP, 3);
        checks++; if (vper !== 20) begin errors++; $display("FAIL duty_lo_period: got %0d expected 20", vper); end
        checks++; if (vht !== MINP) begin errors++; $display("FAIL duty_lo_high: got %0d expected %0d", vht, MINP); end
        pulse(20 - MINP, MINP, 3);
        checks++; if (vper !== 20) begin errors++; $display("FAIL duty_hi_period: got %0d expected 20", vper); end
        checks++; if (vht !== 20 - MINP) begin errors++; $display("FAIL duty_hi_high: got %0d expected %0d", vht, 20 - MINP); end
    endtask

    task automatic test_tick_div;
        tick_div = 4;
        tphase   = 0;
        pulse(20, 20, 4);
        checks++; if (vper !== 10) begin errors++; $display("FAIL tick_period: got %0d expected 10", vper); end
        checks++; if (vht !== 5) begin errors++; $display("FAIL tick_high: got %0d expected 5", vht); end
        tick_div = 1;
        tphase   = 0;
    endtask

    task automatic test_timeout;
        pulse(10, 10, 3);
        stuck_cyc = -1;
        repeat (1100) drive_cycle(1'b0);
        checks++; if (stuck !== 1'b1) begin errors++; $display("FAIL to_stuck: got %b expected 1", stuck); end
        checks++; if (stuck_level !== 1'b0) begin errors++; $display("FAIL to_level: got %b expected 0", stuck_level); end
        checks++; if (stuck_cyc - vcyc !== 1000) begin errors++; $display("FAIL to_delay: got %0d expected 1000", stuck_cyc - vcyc); end
        checks++; if (period !== 10'd20) begin errors++; $display("FAIL to_keep_period: got %0d expected 20", period); end
        checks++; if (high_time !== 10'd10) begin errors++; $display("FAIL to_keep_high: got %0d expected 10", high_time); end
        vcnt = 0;
        pulse(10, 10, 1);
        checks++; if (stuck !== 1'b1) begin errors++; $display("FAIL to_hold_stuck: got %b expected 1", stuck); end
        checks++; if (vcnt !== 0) begin errors++; $display("FAIL to_first_rise: got %0d valids expected 0", vcnt); end
        pulse(10, 10, 2);
        checks++; if (stuck !== 1'b0) begin errors++; $display("FAIL to_clear: got %b expected 0", stuck); end
        checks++; if (vcnt !== 2) begin errors++; $display("FAIL to_resume_cnt: got %0d expected 2", vcnt); end
        checks++; if (vper !== 20) begin errors++; $display("FAIL to_resume_period: got %0d expected 20", vper); end
    endtask

    task automatic test_reset_mid;
        pulse(10, 10, 2);
        repeat (10) drive_cycle(1'b1);
        repeat (5) drive_cycle(1'b0);
        rst_n = 1'b0;
        #1;
        checks++; if (period !== 10'd0) begin errors++; $display("FAIL mid_period: got %0d expected 0", period); end
        checks++; if (high_time !== 10'd0) begin errors++; $display("FAIL mid_high: got %0d expected 0", high_time); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", valid); end
        checks++; if (stuck !== 1'b0) begin errors++; $display("FAIL mid_stuck: got %b expected 0", stuck); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        vcnt  = 0;
        repeat (5) drive_cycle(1'b0);
        pulse(10, 10, 1);
        checks++; if (vcnt !== 0) begin errors++; $display("FAIL mid_first_rise: got %0d valids expected 0", vcnt); end
        pulse(10, 10, 2);
        checks++; if (vcnt !== 2) begin errors++; $display("FAIL mid_cnt: got %0d expected 2", vcnt); end
        checks++; if (vper !== 20) begin errors++; $display("FAIL mid_period2: got %0d expected 20", vper); end
        checks++; if (vht !== 10) begin errors++; $display("FAIL mid_high2: got %0d expected 10", vht); end
    endtask

    task automatic test_glitch;
        int exp_cnt, exp_per, exp_ht;
`ifdef PWM_CAPTURE_FILTER_EN
        exp_cnt = 2; exp_per = 20; exp_ht = 10;
`else
        exp_cnt = 3; exp_per = 14; exp_ht = 4;
`endif
        pulse(10, 10, 2);
        vcnt = 0;
        repeat (4) drive_cycle(1'b1);
        repeat (2) drive_cycle(1'b0);
        repeat (4) drive_cycle(1'b1);
        repeat (10) drive_cycle(1'b0);
        pulse(10, 10, 1);
        checks++; if (vcnt !== exp_cnt) begin errors++; $display("FAIL glitch_cnt: got %0d expected %0d", vcnt, exp_cnt); end
        checks++; if (vper !== exp_per) begin errors++; $display("FAIL glitch_period: got %0d expected %0d", vper, exp_per); end
        checks++; if (vht !== exp_ht) begin errors++; $display("FAIL glitch_high: got %0d expected %0d", vht, exp_ht); end
    endtask

    initial begin
        test_reset();
        test_square();
        test_duty();
        test_tick_div();
        test_timeout();
        test_reset_mid();
        test_glitch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
